// File: rtl/tff_pkg.sv
`timescale 1ns/1ps
// tff_pkg: shared constants and helpers for the toggle flip-flop bank.
//   TFF_DEFAULT_WIDTH : default number of flip-flops in a tff instance
//   TFF_MAX_WIDTH     : largest supported WIDTH
//   toggle_next()     : next state of a single toggle flip-flop
package tff_pkg;

  localparam int TFF_DEFAULT_WIDTH = 1;
  localparam int TFF_MAX_WIDTH     = 64;

  // A toggle flip-flop inverts when t is set and holds otherwise.
  function automatic logic toggle_next(input logic cur, input logic t);
    return cur ^ t;
  endfunction

endpackage

// File: rtl/tff_if.sv
`timescale 1ns/1ps
// tff_if: bundles the toggle-request bus and the state outputs of a tff bank.
//   t  : per-bit toggle request (driven by master)
//   q  : registered flip-flop state (driven by slave)
//   qn : complement of q (driven by slave)
// Modports: master drives t and observes q/qn; slave is the flip-flop bank.
interface tff_if #(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;

  modport master (output t, input q, input qn);
  modport slave  (input t, output q, output qn);

endinterface

// File: rtl/tff_bit.sv
`timescale 1ns/1ps
// tff_bit: one toggle flip-flop with synchronous active-high reset.
//   clk     : clock, state changes on rising edge
//   rst     : synchronous reset, wins over t
//   rst_val : value loaded into q on reset
//   t       : toggle request sampled at the rising edge
//   q       : registered state
module tff_bit
  import tff_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic t,
  output logic q
);

  // State register: reset loads rst_val, otherwise q toggles when t is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= rst_val;
    end else begin
      q <= toggle_next(q, t);
    end
  end

endmodule

// File: rtl/tff.sv
`timescale 1ns/1ps
// tff: bank of WIDTH independent toggle flip-flops.
//   WIDTH   : number of flip-flops (1..TFF_MAX_WIDTH)
//   RST_VAL : value loaded into q by a synchronous reset
//   clk     : clock, all state changes on rising edge
//   rst     : synchronous active-high reset, has priority over t
//   t       : per-bit toggle request
//   q       : registered state, one cycle after t is sampled
//   qn      : ~q, derived combinationally from q only (never from t)
module tff
  import tff_pkg::*;
#(
  parameter int               WIDTH   = TFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
);

  // Reject out-of-range widths at elaboration time.
  if (WIDTH < 1 || WIDTH > TFF_MAX_WIDTH) begin : g_width_check
    $error("tff: WIDTH out of range");
  end

  // One flip-flop per bit; no signal crosses bit positions.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tff_bit u_bit (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RST_VAL[i]),
      .t       (t[i]),
      .q       (q[i])
    );
  end

  assign qn = ~q;

endmodule

// File: tb/tb_tff.sv
`timescale 1ns/1ps
// tb_tff: directed self-checking bench for tff (WIDTH=1 and WIDTH=4 instances).
module tb_tff;

  localparam logic [3:0] RST4 = 4'b0011;

  logic clk = 1'b0;
  logic rst1;
  logic rst4;
  int   tests_run = 0;
  int   fails     = 0;

  tff_if #(.WIDTH(1)) b1 ();
  tff_if #(.WIDTH(4)) b4 ();

  tff #(.WIDTH(1)) u_dut1 (
    .clk (clk), .rst (rst1), .t (b1.t), .q (b1.q), .qn (b1.qn)
  );

  tff #(.WIDTH(4), .RST_VAL(RST4)) u_dut4 (
    .clk (clk), .rst (rst4), .t (b4.t), .q (b4.q), .qn (b4.qn)
  );

  always #5 clk = ~clk;

  // Reference model for the soak: q_next = q ^ t captured at each rising edge.
  logic [3:0] model4;
  logic       soak_on = 1'b0;
  always @(posedge clk) begin
    if (soak_on) model4 = model4 ^ b4.t;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst1 = 1'b1; b1.t = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      tests_run++;
      if (b1.q !== 1'b0 || b1.qn !== 1'b1) begin
        fails++;
        $display("FAIL reset_hold edge%0d: q=%b qn=%b required q=0 qn=1", i, b1.q, b1.qn);
      end
    end
    rst1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (b1.q !== 1'b0 || b1.qn !== 1'b1) begin
        fails++;
        $display("FAIL idle_hold edge%0d: q=%b qn=%b required q=0 qn=1", i, b1.q, b1.qn);
      end
    end
  endtask

  task automatic test_toggle();
    logic [3:0] exp_seq;
    exp_seq = 4'b1010;  // expected q after edges 0..3, MSB first
    b1.t = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if (b1.q !== exp_seq[3-i] || b1.qn !== ~exp_seq[3-i]) begin
        fails++;
        $display("FAIL toggle edge%0d: q=%b qn=%b required q=%b", i, b1.q, b1.qn, exp_seq[3-i]);
      end
    end
  endtask

  task automatic test_reset_priority();
    // q is 0 after the toggle train; one more toggle makes it 1.
    b1.t = 1'b1;
    step();
    tests_run++;
    if (b1.q !== 1'b1) begin
      fails++;
      $display("FAIL prio_setup: q=%b required 1", b1.q);
    end
    rst1 = 1'b1;
    step();
    tests_run++;
    if (b1.q !== 1'b0 || b1.qn !== 1'b1) begin
      fails++;
      $display("FAIL prio_rst_wins: q=%b qn=%b required q=0 qn=1", b1.q, b1.qn);
    end
    rst1 = 1'b0;
    step();
    tests_run++;
    if (b1.q !== 1'b1) begin
      fails++;
      $display("FAIL prio_resume: q=%b required 1", b1.q);
    end
  endtask

  task automatic test_glitch();
    // q is 1 here; t glitches and rst pulses land strictly between edges.
    b1.t = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #2 b1.t = 1'b1;
      #3 b1.t = 1'b0;
      step();
      tests_run++;
      if (b1.q !== 1'b1) begin
        fails++;
        $display("FAIL t_glitch%0d: q=%b required 1", i, b1.q);
      end
    end
    #2 rst1 = 1'b1;
    #3 rst1 = 1'b0;
    step();
    tests_run++;
    if (b1.q !== 1'b1 || b1.qn !== 1'b0) begin
      fails++;
      $display("FAIL rst_glitch: q=%b qn=%b required q=1 qn=0", b1.q, b1.qn);
    end
  endtask

  task automatic test_vector();
    rst4 = 1'b1; b4.t = 4'b1111;
    step();
    tests_run++;
    if (b4.q !== 4'b0011 || b4.qn !== 4'b1100) begin
      fails++;
      $display("FAIL vec_reset: q=%b qn=%b required q=0011 qn=1100", b4.q, b4.qn);
    end
    rst4 = 1'b0; b4.t = 4'b1010;
    step();
    tests_run++;
    if (b4.q !== 4'b1001 || b4.qn !== 4'b0110) begin
      fails++;
      $display("FAIL vec_toggle1: q=%b qn=%b required q=1001 qn=0110", b4.q, b4.qn);
    end
    step();
    tests_run++;
    if (b4.q !== 4'b0011 || b4.qn !== 4'b1100) begin
      fails++;
      $display("FAIL vec_toggle2: q=%b qn=%b required q=0011 qn=1100", b4.q, b4.qn);
    end
  endtask

  task automatic test_soak();
    logic done;
    int   d;
    done = 1'b0;
    b4.t = 4'b0000;
    model4 = 4'b0011;  // state left by test_vector
    soak_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          d = $urandom_range(0, 31);
          #d;
          // keep t changes off the rising edge so sampling is unambiguous
          if (($time % 10) == 5) #1;
          b4.t = 4'($urandom);
        end
        step();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          tests_run++;
          if (b4.q !== model4 || b4.qn !== ~model4) begin
            fails++;
            $display("FAIL soak t=%0t: q=%b qn=%b required q=%b", $time, b4.q, b4.qn, model4);
          end
        end
      end
    join
    soak_on = 1'b0;
  endtask

  initial begin
    rst1 = 1'b1; rst4 = 1'b1;
    b1.t = 1'b0; b4.t = 4'b0000;
    test_reset();
    test_toggle();
    test_reset_priority();
    test_glitch();
    test_vector();
    test_soak();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tff.md
TFF -- requirements
Module: tff

Interface
REQ-001 The module SHALL have parameter WIDTH, default 1, giving the number of independent toggle flip-flops (legal range 1..64).
REQ-002 The module SHALL have parameter RST_VAL, default all-zeros (WIDTH bits), giving the value loaded into q by reset.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port t, input, WIDTH bits: per-bit toggle request, sampled at the rising edge of clk.
REQ-006 The module SHALL have port q, output, WIDTH bits: registered flip-flop state.
REQ-007 The module SHALL have port qn, output, WIDTH bits: bitwise complement of q, combinational from q.

Function
REQ-008 At each rising clk edge with rst=0, each bit i SHALL update as q[i] <= q[i] XOR t[i].
REQ-009 When t[i]=1 at an edge, q[i] SHALL invert; when t[i]=0, q[i] SHALL hold.
REQ-010 Latency from t sampled to q updated SHALL be exactly one clock edge; no combinational path SHALL exist from t to q or qn.
REQ-011 Only the value of t at the rising edge SHALL matter; changes to t between edges, including glitches, SHALL NOT affect q.
REQ-012 Bits SHALL be fully independent; no carry or interaction between bit positions.
REQ-013 q SHALL be constant between rising edges of clk.
REQ-014 qn SHALL equal ~q at all times, including during and after reset.
REQ-015 If t is held at 1, q[i] SHALL toggle every cycle, giving a square wave at half the clk frequency.
REQ-016 Before the first reset edge, q SHALL be treated as undefined; users SHALL apply reset before relying on q.

Reset
REQ-017 On a rising clk edge with rst=1, q SHALL load RST_VAL regardless of t.
REQ-018 rst SHALL take priority over t when both are active at the same edge.
REQ-019 Assertion of rst between edges SHALL have no effect until the next rising edge; there SHALL be no asynchronous path.
REQ-020 On the first edge after rst deasserts, normal toggle behaviour SHALL resume using t at that edge.
REQ-021 Reset asserted mid-toggle-sequence SHALL force RST_VAL at the next edge and SHALL NOT preserve any prior phase.

Structure
REQ-022 A shared package tff_pkg SHALL hold the default WIDTH constant and the maximum-width constant.
REQ-023 A single-bit sub-module tff_bit (clk, rst, rst_val, t, q) SHALL implement one flip-flop.
REQ-024 tff SHALL instantiate tff_bit WIDTH times via a generate loop and derive qn at the top level.
REQ-025 The design SHALL be fully synthesizable, use only flip-flops plus XOR logic, and contain no latches.

Verification
REQ-026 Reset and hold: WIDTH=1, rst=1 for 2 edges, t=0, then rst=0 with t=0 for 3 edges -> q=0 and qn=1 throughout.
REQ-027 Toggle train: after reset, t=1 for 4 edges -> q=1,0,1,0 after successive edges, and qn is its complement.
REQ-028 Reset priority: with q=1, assert rst=1 with t=1 at one edge -> q=0 after that edge; rst=0 with t=1 at the next edge -> q=1.
REQ-029 Between-edge glitch: pulse t high for 3 time units between edges, with t low at every edge -> q unchanged.
REQ-030 Vector and RST_VAL: WIDTH=4, RST_VAL=4'b0011, reset, then t=4'b1010 for 2 edges -> q=1001 then 0011.
REQ-031 Random soak: 20 random t values applied at random delays of 0..31 time units with clk period 10 -> q matches a reference model q_next = q XOR t, sampled at each edge.
